// File: rtl/dec_stream_pkg.sv
// dec_stream shared types and constants.
// FSM state encoding and opcode mode values.
package dec_stream_pkg;

  typedef enum logic [1:0] {
    S_OP  = 2'd0,
    S_IMM = 2'd1,
    S_OUT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_IMM = 2'b11;
  localparam logic [1:0] IMM_MODE_DEF = MODE_IMM;

endpackage

// File: rtl/dec_stream_if.sv
// Byte-in / instruction-out handshake bundle.
// slave = decoder side, master = producer/consumer side.
interface dec_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_op;
  logic [WIDTH-1:0] out_mode_lo;
  logic [WIDTH-1:0] out_mode_hi;
  logic [WIDTH-1:0] out_imm;
  logic             out_has_imm;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_op,
    output out_mode_lo, out_mode_hi,
    output out_imm, out_has_imm
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_op,
    input  out_mode_lo, out_mode_hi,
    input  out_imm, out_has_imm
  );
endinterface

// File: rtl/dec_stream_field.sv
// Opcode field slicer: mode bits and
// immediate-follows flag.
module dec_field
  import dec_stream_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         MODE_LSB = 6,
  parameter logic [1:0] IMM_MODE = IMM_MODE_DEF
) (
  input  logic [WIDTH-1:0] op,
  output logic [WIDTH-1:0] mode_lo,
  output logic [WIDTH-1:0] mode_hi,
  output logic             needs_imm
);
  logic [1:0] mode;
  logic       op_unused;

  assign mode = op[MODE_LSB+1:MODE_LSB];
  assign op_unused = ^op;

  assign mode_lo = {{(WIDTH-1){1'b0}}, mode[0]};
  assign mode_hi = {{(WIDTH-1){1'b0}}, mode[1]};
  assign needs_imm = (mode == IMM_MODE);
endmodule

// File: rtl/dec_stream.sv
// Streaming 1/2-byte instruction assembler.
// Bytes in on valid/ready, instructions out on valid/ready.
module dec_stream
  import dec_stream_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         MODE_LSB = 6,
  parameter logic [1:0] IMM_MODE = IMM_MODE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  dec_stream_if.slave  s
);
  state_t           state;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] imm_q;
  logic             has_q;
  logic             live;
  logic             in_fire;
  logic             out_fire;
  logic             in_imm;
  logic             op_imm_unused;
  logic [WIDTH-1:0] in_lo_unused;
  logic [WIDTH-1:0] in_hi_unused;

  dec_field #(
    .WIDTH(WIDTH), .MODE_LSB(MODE_LSB),
    .IMM_MODE(IMM_MODE)
  ) u_held (
    .op(op_q),
    .mode_lo(s.out_mode_lo),
    .mode_hi(s.out_mode_hi),
    .needs_imm(op_imm_unused)
  );

  dec_field #(
    .WIDTH(WIDTH), .MODE_LSB(MODE_LSB),
    .IMM_MODE(IMM_MODE)
  ) u_next (
    .op(s.in_data),
    .mode_lo(in_lo_unused),
    .mode_hi(in_hi_unused),
    .needs_imm(in_imm)
  );

  // rst/flush blank both handshakes in the same cycle
  assign live = !rst && !flush;
  assign s.in_ready = live &&
    ((state != S_OUT) || s.out_ready);
  assign s.out_valid = live && (state == S_OUT);

  assign in_fire  = s.in_valid && s.in_ready;
  assign out_fire = s.out_valid && s.out_ready;

  assign s.out_op      = op_q;
  assign s.out_imm     = imm_q;
  assign s.out_has_imm = has_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OP;
      op_q  <= '0;
      imm_q <= '0;
      has_q <= 1'b0;
    end else if (flush) begin
      state <= S_OP;
    end else if (in_fire) begin
      unique case (1'b1)
        (state == S_IMM): begin
          imm_q <= s.in_data;
          has_q <= 1'b1;
          state <= S_OUT;
        end
        default: begin
          op_q  <= s.in_data;
          imm_q <= '0;
          has_q <= 1'b0;
          state <= in_imm ? S_IMM : S_OUT;
        end
      endcase
    end else if (out_fire) begin
      state <= S_OP;
    end
  end
endmodule

// File: tb/tb_dec_stream.sv
// Self-checking bench for dec_stream: directed
// scenarios plus randomized run against a byte-stream model.
module tb_dec_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  dec_stream_if #(.WIDTH(8)) bus ();

  dec_stream dut (
    .clk(clk), .rst(rst),
    .flush(flush), .s(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v,
                       input logic [7:0] d,
                       input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b1, 8'hC3, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hs: in_ready=%b out_valid=%b want 0 0",
               bus.in_ready, bus.out_valid);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_hs: in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    n_chk++;
    if ({bus.out_op, bus.out_imm, bus.out_mode_lo,
         bus.out_mode_hi, bus.out_has_imm} !== 33'd0) begin
      n_fail++;
      $display("FAIL rst_outs: op=%h imm=%h lo=%h hi=%h has=%b want all 0",
               bus.out_op, bus.out_imm, bus.out_mode_lo,
               bus.out_mode_hi, bus.out_has_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_one_byte();
    drive(1'b1, 8'h45, 1'b1);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL one_accept: in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== 8'h45 ||
        bus.out_mode_lo !== 8'd1 || bus.out_mode_hi !== 8'd0 ||
        bus.out_has_imm !== 1'b0 || bus.out_imm !== 8'd0) begin
      n_fail++;
      $display("FAIL one_out: v=%b op=%h lo=%h hi=%h has=%b imm=%h want 1 45 01 00 0 00",
               bus.out_valid, bus.out_op, bus.out_mode_lo,
               bus.out_mode_hi, bus.out_has_imm, bus.out_imm);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL one_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_two_byte();
    drive(1'b1, 8'hC3, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h7F, 1'b1);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL two_mid: out_valid=%b in_ready=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== 8'hC3 ||
        bus.out_mode_lo !== 8'd1 || bus.out_mode_hi !== 8'd1 ||
        bus.out_has_imm !== 1'b1 || bus.out_imm !== 8'h7F) begin
      n_fail++;
      $display("FAIL two_out: v=%b op=%h lo=%h hi=%h has=%b imm=%h want 1 c3 01 01 1 7f",
               bus.out_valid, bus.out_op, bus.out_mode_lo,
               bus.out_mode_hi, bus.out_has_imm, bus.out_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 8'(i + 1), 1'b1);
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b want 1",
                 i, bus.in_ready);
      end
      if (i > 0) begin
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_op !== 8'(i)) begin
          n_fail++;
          $display("FAIL b2b_op[%0d]: v=%b op=%h want 1 %h",
                   i, bus.out_valid, bus.out_op, 8'(i));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'h10, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_op !== 8'h10 || bus.out_has_imm !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: rdy=%b v=%b op=%h has=%b want 0 1 10 0",
                 i, bus.in_ready, bus.out_valid,
                 bus.out_op, bus.out_has_imm);
      end
      @(negedge clk);
    end
    drive(1'b1, 8'h20, 1'b1);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_op !== 8'h10) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b op=%h want 1 10",
               bus.in_ready, bus.out_op);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== 8'h20) begin
      n_fail++;
      $display("FAIL bp_next: v=%b op=%h want 1 20",
               bus.out_valid, bus.out_op);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    drive(1'b1, 8'hC3, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 8'h55, 1'b1);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hs: rdy=%b v=%b want 0 0",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b1, 8'h05, 1'b1);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: rdy=%b v=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== 8'h05 ||
        bus.out_has_imm !== 1'b0 || bus.out_imm !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_op: v=%b op=%h has=%b imm=%h want 1 05 0 00",
               bus.out_valid, bus.out_op,
               bus.out_has_imm, bus.out_imm);
    end
    @(negedge clk);
  endtask

  // Model: bytes form a stream; an opcode whose bits
  // [7:6] equal 3 swallows the next byte as its immediate.
  task automatic test_random();
    bit       have = 0;
    bit       pend = 0;
    bit [7:0] p_op = 0;
    bit [7:0] e_op = 0;
    bit [7:0] e_imm = 0;
    bit       e_has = 0;
    bit       v, r, f, e_iv, e_ov;
    bit [7:0] d;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      f = ($urandom % 20) == 0;
      d = 8'($urandom);
      flush = f;
      drive(v, d, r);
      #1;
      e_ov = !f && have;
      e_iv = !f && (!have || r);
      n_chk++;
      if (bus.out_valid !== e_ov || bus.in_ready !== e_iv) begin
        n_fail++;
        $display("FAIL rnd_hs[%0d]: v=%b rdy=%b want %b %b",
                 c, bus.out_valid, bus.in_ready, e_ov, e_iv);
      end
      if (have) begin
        n_chk++;
        if (bus.out_op !== e_op || bus.out_imm !== e_imm ||
            bus.out_has_imm !== e_has ||
            bus.out_mode_lo !== 8'((e_op / 64) % 2) ||
            bus.out_mode_hi !== 8'(e_op / 128)) begin
          n_fail++;
          $display("FAIL rnd_out[%0d]: op=%h imm=%h has=%b lo=%h hi=%h want %h %h %b",
                   c, bus.out_op, bus.out_imm, bus.out_has_imm,
                   bus.out_mode_lo, bus.out_mode_hi,
                   e_op, e_imm, e_has);
        end
      end
      if (f) begin
        have = 0;
        pend = 0;
      end else begin
        if (e_ov && r) have = 0;
        if (e_iv && v) begin
          if (pend) begin
            e_op = p_op; e_imm = d; e_has = 1;
            have = 1; pend = 0;
          end else if (d / 64 == 3) begin
            p_op = d; pend = 1;
          end else begin
            e_op = d; e_imm = 0; e_has = 0;
            have = 1;
          end
        end
      end
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    test_reset();
    test_one_byte();
    test_two_byte();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
